sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single external 16-bit SRAM between NUM_REQ requesters: background loader, sprite/trail loader and score/text loader.
- Each requester uses the same level-request / done-pulse handshake: hold req, wait for done.
- Performs one access per grant, with a programmable wait-state count to meet SRAM timing.
- Drives the SRAM control pins and returns read data to the granted requester.

Parameters:
- NUM_REQ, 3: number of requesters; index 0 is the background loader.
- ADDR_W, 20: SRAM word-address width.
- DATA_W, 16: SRAM data width.
- WAIT_CYCLES, 2: clock cycles the access is held before data is sampled or the write completes; legal range 1 to 7.

Ports:
- Clk  in  1  system clock; all logic is rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  level request per requester.
- wr  in  NUM_REQ  1 = write, 0 = read; sampled with addr_in at grant.
- addr_in  in  NUM_REQ*ADDR_W  packed per-requester word address; requester i uses slice [i*ADDR_W +: ADDR_W].
- wdata_in  in  NUM_REQ*DATA_W  packed per-requester write data.
- done  out  NUM_REQ  one-cycle completion pulse to the served requester.
- grant  out  NUM_REQ  one-hot; marks the requester currently owning the SRAM.
- rdata  out  DATA_W  read data; valid in the done cycle and held until the next read completes.
- SRAM_ADDR  out  ADDR_W  SRAM address.
- Data_to_SRAM  out  DATA_W  write data.
- Data_from_SRAM  in  DATA_W  read data from the pad buffer.
- SRAM_OE_N, SRAM_WE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM controls.
- SRAM_DRIVE  out  1  tri-state enable to the top-level DQ buffer; 1 only during a write access.

Behaviour:
- Reset values: state = IDLE, grant = 0, done = 0, rdata = 0, SRAM_ADDR = 0, Data_to_SRAM = 0, rr_ptr = 0.
- Reset values of SRAM controls: SRAM_OE_N, SRAM_WE_N and SRAM_CE_N = 1; SRAM_UB_N and SRAM_LB_N = 1; SRAM_DRIVE = 0.
- Reset asserted mid-access aborts the access with no done pulse. A write may be partially applied; this is acceptable.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If any req bit is 1, select the winner by round-robin starting at rr_ptr. Scan indices rr_ptr, rr_ptr+1, … modulo NUM_REQ; the first set bit wins.
  - On selection: latch the winner's addr, wr and wdata into registers; set grant one-hot; clear wait_cnt; go to ACCESS.
  - Arbitration decision takes exactly one cycle: from req seen to first ACCESS cycle.
- ACCESS:
  - CE_N = 0, UB_N = 0, LB_N = 0.
  - Read: OE_N = 0, WE_N = 1.
  - Write: OE_N = 1, WE_N = 0, SRAM_DRIVE = 1.
  - SRAM_ADDR and Data_to_SRAM come from the latched registers and are stable for the whole access.
  - wait_cnt increments each cycle. When wait_cnt == WAIT_CYCLES-1, a read captures Data_from_SRAM into rdata, and the state goes to DONE.
  - ACCESS therefore lasts exactly WAIT_CYCLES cycles.
- DONE:
  - done[g] = 1 for exactly this one cycle. Control pins are inactive (WE_N rises a full cycle before the next address change).
  - rr_ptr = (g+1) mod NUM_REQ. grant is cleared. Go to IDLE.
- Latency: req high in IDLE gives done after 1 + WAIT_CYCLES + 1 cycles; 4 cycles at default.
- Requester rule:
  - A requester must drop req in the cycle after done, or it is treated as a new request.
  - It then competes behind the other requesters because rr_ptr has advanced, which gives starvation freedom.
  - addr_in, wr and wdata_in changing after grant have no effect on the current access.
- Simultaneous requests: exactly one grant per arbitration cycle; losers wait with no done pulse. A req deasserted before being granted is simply dropped.
- rr_ptr wrap: with NUM_REQ = 3, after serving index 2 the pointer returns to 0.
- Width rules: wait_cnt is 3 bits; rr_ptr is $clog2(NUM_REQ) bits; address is never modified by the arbiter (no increment).

Decomposition:
- Package tron_mem_pkg holds:
  - the state enum arb_state_t;
  - constants SRAM_ADDR_W = 20 and SRAM_DATA_W = 16;
  - requester index constants REQ_BG = 0, REQ_SPRITE = 1, REQ_TEXT = 2.
- One sub-module, rr_picker: combinational round-robin picker with inputs (req, rr_ptr) and outputs (one-hot, index).
- The FSM and SRAM pin drive stay in sram_arbiter.

Test Plan:
1. Reset while in ACCESS with a write → next cycle all *_N = 1, SRAM_DRIVE = 0, grant = 0, no done pulse; after release state = IDLE.
2. Only req[0]=1, wr=0, addr=20'h25801, SRAM model returns 16'h0F0F → SRAM_ADDR = 20'h25801 for 2 cycles with OE_N = 0; done[0] pulses in cycle 4; rdata = 16'h0F0F and held afterwards.
3. req[1] write, addr=20'h00010, wdata=16'hA5A5 → WE_N = 0 and SRAM_DRIVE = 1 for 2 cycles; model memory[0x10] = 16'hA5A5; done[1] pulses; rdata unchanged.
4. req = 3'b111 held continuously, with each requester dropping req for one cycle after its own done → grant order 0, 1, 2, 0, 1, 2; no index is served twice in a row.
5. req[0] kept high through done → second access to the same address, but only after index 1 is served if req[1] was pending; confirms rr_ptr advance.
6. WAIT_CYCLES = 4 build, single read → ACCESS lasts 4 cycles; done arrives 6 cycles after req.

Source files
------------

// File: rtl/tron_mem_pkg.sv
// tron_mem_pkg: shared types and constants for the SRAM arbiter and its requesters.
// Contents: arb_state_t FSM encoding, SRAM geometry, requester index assignments.
package tron_mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;
    localparam int REQ_BG      = 0;
    localparam int REQ_SPRITE  = 1;
    localparam int REQ_TEXT    = 2;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin picker; first set req bit scanning from rr_ptr upward, wrapping.
// Ports: req (request vector), rr_ptr (scan start index), onehot (winner one-hot), index (winner index).
module rr_picker #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] index
);
    logic [PW-1:0] j;
    logic          found;

    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        j      = '0;
        for (int k = 0; k < N; k++) begin
            j = PW'((int'(rr_ptr) + k) % N);
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                index     = j;
            end
        end
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one asynchronous 16-bit SRAM between NUM_REQ requesters.
// Ports: Clk/Reset; per-requester req, wr, addr_in, wdata_in in; done, grant out; rdata out;
//        SRAM_ADDR, Data_to_SRAM, active-low SRAM controls and SRAM_DRIVE to the pads; Data_from_SRAM in.
module sram_arbiter
    import tron_mem_pkg::*;
#(
    parameter int NUM_REQ     = REQ_TEXT + 1,
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        wr,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_in,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         SRAM_ADDR,
    output logic [DATA_W-1:0]         Data_to_SRAM,
    input  logic [DATA_W-1:0]         Data_from_SRAM,
    output logic                      SRAM_OE_N,
    output logic                      SRAM_WE_N,
    output logic                      SRAM_CE_N,
    output logic                      SRAM_UB_N,
    output logic                      SRAM_LB_N,
    output logic                      SRAM_DRIVE
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           state, state_nx;
    logic [2:0]           wait_cnt;
    logic [PW-1:0]        rr_ptr, g_idx, pick_idx;
    logic [NUM_REQ-1:0]   pick_oh, g_oh;
    logic                 wr_q, last, acc;

    assign last = wait_cnt == 3'(WAIT_CYCLES - 1);

    rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .onehot (pick_oh),
        .index  (pick_idx)
    );

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) state <= IDLE;
        else       state <= state_nx;

    always_comb
        state_nx = (state == IDLE)   ? ((|req) ? ACCESS : IDLE) :
                   (state == ACCESS) ? (last ? DONE : ACCESS) : IDLE;

    // The SRAM address and write data are registered at grant so the pins stay
    // stable for the whole access and hold their value while idle.
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            wait_cnt     <= '0;
            rr_ptr       <= PW'(REQ_BG);
            g_idx        <= '0;
            g_oh         <= '0;
            wr_q         <= 1'b0;
            SRAM_ADDR    <= '0;
            Data_to_SRAM <= '0;
            rdata        <= '0;
        end else if (state == IDLE) begin
            if (|req) begin
                g_idx        <= pick_idx;
                g_oh         <= pick_oh;
                wr_q         <= wr[pick_idx];
                SRAM_ADDR    <= addr_in[pick_idx*ADDR_W +: ADDR_W];
                Data_to_SRAM <= wdata_in[pick_idx*DATA_W +: DATA_W];
                wait_cnt     <= '0;
            end
        end else if (state == ACCESS) begin
            wait_cnt <= wait_cnt + 3'd1;
            if (last && !wr_q) rdata <= Data_from_SRAM;
        end else if (state == DONE) begin
            rr_ptr <= (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
        end

    // Controls are asserted only in ACCESS, so DONE gives a full inactive cycle
    // before the next address is launched.
    always_comb begin
        acc        = state == ACCESS;
        grant      = acc ? g_oh : '0;
        done       = (state == DONE) ? g_oh : '0;
        SRAM_CE_N  = !acc;
        SRAM_UB_N  = !acc;
        SRAM_LB_N  = !acc;
        SRAM_OE_N  = !(acc && !wr_q);
        SRAM_WE_N  = !(acc && wr_q);
        SRAM_DRIVE = acc && wr_q;
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: self-checking bench for sram_arbiter with a behavioural arbiter model and SRAM model.
module tb_sram_arbiter;
    import tron_mem_pkg::*;

    localparam int N  = 3;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int W  = 2;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic [N-1:0]    req, wr, done, grant;
    logic [N*AW-1:0] addr_in;
    logic [N*DW-1:0] wdata_in;
    logic [DW-1:0]   rdata, Data_to_SRAM, Data_from_SRAM;
    logic [AW-1:0]   SRAM_ADDR;
    logic            SRAM_OE_N, SRAM_WE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DRIVE;

    sram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .wr(wr), .addr_in(addr_in), .wdata_in(wdata_in),
        .done(done), .grant(grant), .rdata(rdata), .SRAM_ADDR(SRAM_ADDR),
        .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
        .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_CE_N(SRAM_CE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_DRIVE(SRAM_DRIVE)
    );

    // Second instance built with four wait states, fed by its own request vector.
    logic [N-1:0]    req4, done4, grant4;
    logic [N*AW-1:0] addr4;
    logic [N*DW-1:0] wd4;
    logic [DW-1:0]   rdata4, dt4, df4;
    logic [AW-1:0]   sa4;
    logic            oe4, we4, ce4, ub4, lb4, dr4;

    sram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .req(req4), .wr(3'b000), .addr_in(addr4), .wdata_in(wd4),
        .done(done4), .grant(grant4), .rdata(rdata4), .SRAM_ADDR(sa4),
        .Data_to_SRAM(dt4), .Data_from_SRAM(df4),
        .SRAM_OE_N(oe4), .SRAM_WE_N(we4), .SRAM_CE_N(ce4),
        .SRAM_UB_N(ub4), .SRAM_LB_N(lb4), .SRAM_DRIVE(dr4)
    );

    // SRAM model, aliased on the low 12 address bits, preloaded on the first clock.
    logic [15:0] sram [4096];
    logic        mem_ready = 1'b0;
    assign Data_from_SRAM = (!SRAM_CE_N && !SRAM_OE_N) ? sram[SRAM_ADDR[11:0]] : 16'hDEAD;
    always @(posedge Clk)
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) sram[i] <= 16'(i * 40503 + 7);
            sram[12'h801] <= 16'h0F0F;
            mem_ready <= 1'b1;
        end else if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DRIVE)
            sram[SRAM_ADDR[11:0]] <= Data_to_SRAM;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: mp = -1 idle, 1..W access cycles, W+1 done cycle.
    logic [15:0] mm [4096];
    int          mp, mown, mptr;
    logic        mwr;
    logic [19:0] maddr;
    logic [15:0] mwd, mrd;

    task automatic model_step();
        if (Reset) begin
            mp = -1; mown = 0; mptr = 0; mwr = 1'b0; maddr = '0; mwd = '0; mrd = '0;
            return;
        end
        if (mp < 0) begin
            if (|req) begin
                int pick = -1;
                for (int k = 0; k < N; k++)
                    if (pick < 0 && req[(mptr + k) % N]) pick = (mptr + k) % N;
                mown  = pick;
                mwr   = wr[pick];
                maddr = addr_in[pick*AW +: AW];
                mwd   = wdata_in[pick*DW +: DW];
                mp    = 1;
            end
        end else if (mp < W) mp++;
        else if (mp == W) begin
            if (mwr) mm[maddr[11:0]] = mwd;
            else     mrd = mm[maddr[11:0]];
            mp = W + 1;
        end else begin
            mptr = (mown + 1) % N;
            mp   = -1;
        end
    endtask

    task automatic compare_all();
        bit acc, dn;
        acc = mp >= 1 && mp <= W;
        dn  = mp == W + 1;
        chk("grant", 32'(grant), acc ? 32'(1 << mown) : 32'd0);
        chk("done", 32'(done), dn ? 32'(1 << mown) : 32'd0);
        chk("rdata", 32'(rdata), 32'(mrd));
        chk("sram_addr", 32'(SRAM_ADDR), 32'(maddr));
        chk("data_to_sram", 32'(Data_to_SRAM), 32'(mwd));
        chk("ctl", 32'({SRAM_OE_N, SRAM_WE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DRIVE}),
            32'(acc ? {mwr, !mwr, 3'b000, mwr} : 6'b111110));
    endtask

    task automatic adv();
        model_step();
        @(negedge Clk);
        compare_all();
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        req = '0;
        adv();
        Reset = 1'b0;
        adv();
    endtask

    int  ord[$];
    int  exp4[6] = '{REQ_BG, REQ_SPRITE, REQ_TEXT, REQ_BG, REQ_SPRITE, REQ_TEXT};
    int  exp5[3] = '{REQ_BG, REQ_SPRITE, REQ_BG};
    int  n, acc4;
    bit  got, served1;

    initial begin
        req = '0; wr = '0; addr_in = '0; wdata_in = '0;
        req4 = '0; addr4 = '0; wd4 = '0; df4 = 16'h1234;
        for (int i = 0; i < 4096; i++) mm[i] = 16'(i * 40503 + 7);
        mm[12'h801] = 16'h0F0F;
        model_step();
        @(negedge Clk);
        compare_all();
        chk("rst_ctl", 32'({SRAM_OE_N, SRAM_WE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DRIVE}), 32'h3E);
        chk("rst_grant_done", 32'({grant, done}), 32'd0);
        chk("rst_rdata_addr", 32'({rdata, SRAM_ADDR[15:0]}), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        adv();

        // Reset in the middle of a write access.
        req = 3'b100; wr = 3'b100;
        addr_in[2*AW +: AW] = 20'hFFFFF; wdata_in[2*DW +: DW] = 16'hBEEF;
        adv();
        chk("t1_we_low", 32'(SRAM_WE_N), 32'd0);
        chk("t1_grant", 32'(grant), 32'b100);
        req = '0; wr = '0;
        Reset = 1'b1;
        adv();
        chk("t1_ctl_idle", 32'({SRAM_OE_N, SRAM_WE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DRIVE}), 32'h3E);
        chk("t1_grant_clr", 32'(grant), 32'd0);
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            adv();
            chk("t1_no_done", 32'(done), 32'd0);
        end

        // Single read by the background loader.
        req = 3'b001; addr_in[0 +: AW] = 20'h25801;
        adv();
        chk("t2_addr1", 32'(SRAM_ADDR), 32'h25801);
        chk("t2_oe1", 32'(SRAM_OE_N), 32'd0);
        adv();
        chk("t2_addr2", 32'(SRAM_ADDR), 32'h25801);
        chk("t2_oe2", 32'(SRAM_OE_N), 32'd0);
        adv();
        chk("t2_done", 32'(done), 32'b001);
        chk("t2_rdata", 32'(rdata), 32'h0F0F);
        req = '0;
        adv();
        chk("t2_done_gone", 32'(done), 32'd0);
        chk("t2_rdata_hold", 32'(rdata), 32'h0F0F);

        // Single write by the sprite loader; late address change must be ignored.
        req = 3'b010; wr = 3'b010;
        addr_in[AW +: AW] = 20'h00010; wdata_in[DW +: DW] = 16'hA5A5;
        adv();
        chk("t3_we1", 32'({SRAM_WE_N, SRAM_DRIVE}), 32'b01);
        addr_in[AW +: AW] = 20'h00333; wdata_in[DW +: DW] = 16'h1111;
        adv();
        chk("t3_we2", 32'({SRAM_WE_N, SRAM_DRIVE}), 32'b01);
        chk("t3_addr", 32'(SRAM_ADDR), 32'h00010);
        adv();
        chk("t3_done", 32'(done), 32'b010);
        chk("t3_rdata_keep", 32'(rdata), 32'h0F0F);
        req = '0; wr = '0;
        adv();
        chk("t3_mem", 32'(sram[12'h010]), 32'hA5A5);

        // All three requesting, each drops for one cycle after its own done.
        pulse_reset();
        req = 3'b111;
        ord.delete();
        for (int c = 0; c < 60 && ord.size() < 6; c++) begin
            adv();
            for (int i = 0; i < N; i++) if (done[i]) ord.push_back(i);
            req = ~done;
        end
        req = '0;
        adv();
        chk("t4_count", 32'(ord.size()), 32'd6);
        for (int i = 0; i < ord.size() && i < 6; i++) chk("t4_order", 32'(ord[i]), 32'(exp4[i]));

        // Background loader holds req through done while the sprite loader is pending.
        pulse_reset();
        req = 3'b011; addr_in[0 +: AW] = 20'h00005;
        ord.delete();
        served1 = 1'b0;
        for (int c = 0; c < 60 && ord.size() < 3; c++) begin
            adv();
            for (int i = 0; i < N; i++) if (done[i]) ord.push_back(i);
            if (done[1]) served1 = 1'b1;
            req[1] = !done[1] && !served1;
        end
        req = '0;
        adv();
        adv();
        chk("t5_count", 32'(ord.size()), 32'd3);
        for (int i = 0; i < ord.size() && i < 3; i++) chk("t5_order", 32'(ord[i]), 32'(exp5[i]));

        // Four-wait-state build: latency counted in clock edges after req is driven.
        req4 = 3'b001; n = 0; acc4 = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            adv();
            n++;
            if (!oe4) acc4++;
            if (done4[0]) begin got = 1'b1; req4 = '0; end
        end
        chk("w4_done_seen", 32'(got), 32'd1);
        chk("w4_latency", 32'(n), 32'd5);
        chk("w4_access_len", 32'(acc4), 32'd4);
        chk("w4_rdata", 32'(rdata4), 32'h1234);
        adv();
        adv();
        chk("w4_idle", 32'({oe4, we4, ce4, ub4, lb4, dr4, grant4, done4}), 32'h3E << 6);
        chk("w4_rdata_hold", 32'({rdata4, sa4[15:0]}), 32'h12340000);
        chk("w4_wdata", 32'(dt4), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    if ($urandom_range(0, 4) != 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        wr[i]  = 1'($urandom);
                        addr_in[i*AW +: AW]  = {8'($urandom), 8'h00, 4'($urandom)};
                        wdata_in[i*DW +: DW] = 16'($urandom);
                    end
                end else if (mp >= 1 && mown == i) begin
                    wr[i] = 1'($urandom);
                    addr_in[i*AW +: AW]  = {8'($urandom), 8'h00, 4'($urandom)};
                    wdata_in[i*DW +: DW] = 16'($urandom);
                end else if (mp < 0 && $urandom_range(0, 40) == 0) req[i] = 1'b0;
            end
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
